// File: rtl/fire_control_pkg.sv
// Shared widths, the fire FSM state type and LFSR seed sanitising
// used by the fire_control block and its LFSR.
package fire_control_pkg;

   localparam int FRAME_COUNT_WIDTH = 8;
   localparam int LFSR_WIDTH        = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FIRE     = 2'd1,
      ST_COOLDOWN = 2'd2
   } fire_state_t;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   function automatic logic [LFSR_WIDTH-1:0] fix_seed(input logic [LFSR_WIDTH-1:0] s);
      return (s == '0) ? LFSR_WIDTH'(1) : s;
   endfunction

endpackage

// File: rtl/fire_control_if.sv
// Game-side signals of one fire_control instance: controls in, fire
// command, ready flag and shot counter out.
interface fire_control_if;
   import fire_control_pkg::*;

   logic                         enable;
   logic                         startOfFrame;
   logic                         fire_key;
   logic                         auto_mode;
   logic                         shooting_pulse;
   logic                         ready;
   logic [FRAME_COUNT_WIDTH-1:0] shot_count;

   modport master (
      output enable, startOfFrame, fire_key, auto_mode,
      input  shooting_pulse, ready, shot_count
   );

   modport slave (
      input  enable, startOfFrame, fire_key, auto_mode,
      output shooting_pulse, ready, shot_count
   );

endinterface

// File: rtl/fire_control_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) stepping every clock;
// reset loads the sanitised seed.
module lfsr16
   import fire_control_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [LFSR_WIDTH-1:0] seed,
   output logic [LFSR_WIDTH-1:0] value
);

   logic feedback;

   assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

   always_ff @(posedge clk) begin
      if (reset) begin
         value <= fix_seed(seed);
      end else begin
         value <= {value[14:0], feedback};
      end
   end

endmodule

// File: rtl/fire_control.sv
// Shot scheduler for one missile bank: key-driven (player) or random
// auto-fire (enemy), with a per-shot cooldown measured in frames.
module fire_control
   import fire_control_pkg::*;
#(
   parameter int unsigned           COOLDOWN_FRAMES = 8,
   parameter int unsigned           AUTO_MIN_FRAMES = 30,
   parameter logic [LFSR_WIDTH-1:0] AUTO_MASK       = 16'h003F,
   parameter logic [LFSR_WIDTH-1:0] LFSR_SEED       = 16'hACE1
) (
   input logic         clk,
   input logic         reset,
   fire_control_if.slave bus
);

   localparam int FCW = FRAME_COUNT_WIDTH;
   localparam logic [LFSR_WIDTH-1:0] SEED_EFF = fix_seed(LFSR_SEED);
   localparam logic [FCW-1:0]        CD_LOAD  = FCW'(COOLDOWN_FRAMES);

   if ((AUTO_MIN_FRAMES + 32'(AUTO_MASK)) > ((32'd1 << FCW) - 32'd1)) begin : g_auto_range
      $error("fire_control: AUTO_MIN_FRAMES + AUTO_MASK exceeds the frame counter width");
   end
   if (COOLDOWN_FRAMES > ((32'd1 << FCW) - 32'd1)) begin : g_cd_range
      $error("fire_control: COOLDOWN_FRAMES exceeds the frame counter width");
   end

   // Auto-fire reload: fixed minimum plus a masked random extra delay.
   function automatic logic [FCW-1:0] auto_load(input logic [LFSR_WIDTH-1:0] r);
      return FCW'(AUTO_MIN_FRAMES + 32'(r & AUTO_MASK));
   endfunction

   logic [LFSR_WIDTH-1:0] lfsr_value;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (SEED_EFF),
      .value (lfsr_value)
   );

   // Two-flop synchronizer, then a third flop for edge detection.
   logic key_meta, key_sync, key_prev, key_edge;

   always_ff @(posedge clk) begin
      if (reset) begin
         key_meta <= 1'b0;
         key_sync <= 1'b0;
         key_prev <= 1'b0;
         key_edge <= 1'b0;
      end else begin
         key_meta <= bus.fire_key;
         key_sync <= key_meta;
         key_prev <= key_sync;
         key_edge <= key_sync & ~key_prev;
      end
   end

   fire_state_t    state;
   logic           pulse;
   logic [FCW-1:0] shot_count;
   logic [FCW-1:0] wait_cnt;
   logic [FCW-1:0] cd_cnt;
   logic           auto_q;
   logic           mode_change;
   logic           start_fire;

   assign mode_change = (bus.auto_mode != auto_q);

   always_comb begin
      start_fire = 1'b0;
      if (state == ST_IDLE && bus.enable && !mode_change) begin
         if (bus.auto_mode) begin
            start_fire = bus.startOfFrame && (wait_cnt < FCW'(2));
         end else begin
            start_fire = key_edge;
         end
      end
   end

   always_ff @(posedge clk) begin
      auto_q <= bus.auto_mode;
      if (reset) begin
         state      <= ST_IDLE;
         pulse      <= 1'b0;
         shot_count <= '0;
         cd_cnt     <= '0;
         wait_cnt   <= auto_load(SEED_EFF);
      end else if (!bus.enable) begin
         state    <= ST_IDLE;
         pulse    <= 1'b0;
         cd_cnt   <= '0;
         wait_cnt <= auto_load(lfsr_value);
      end else begin
         pulse <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (mode_change) begin
                  wait_cnt <= auto_load(lfsr_value);
               end else if (start_fire) begin
                  state      <= ST_FIRE;
                  pulse      <= 1'b1;
                  shot_count <= shot_count + 1'b1;
                  wait_cnt   <= '0;
               end else if (bus.auto_mode && bus.startOfFrame) begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_FIRE: begin
               if (COOLDOWN_FRAMES == 0) begin
                  state    <= ST_IDLE;
                  wait_cnt <= auto_load(lfsr_value);
               end else begin
                  state  <= ST_COOLDOWN;
                  cd_cnt <= CD_LOAD;
               end
            end
            ST_COOLDOWN: begin
               if (bus.startOfFrame) begin
                  cd_cnt <= cd_cnt - 1'b1;
                  if (cd_cnt < FCW'(2)) begin
                     state    <= ST_IDLE;
                     wait_cnt <= auto_load(lfsr_value);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.shooting_pulse = pulse;
   assign bus.ready          = (state == ST_IDLE);
   assign bus.shot_count     = shot_count;

endmodule
